// File: rtl/sim_run_monitor.sv
// End-of-simulation monitor: counts cycles/retirements until halt PC or timeout,
// then freezes the CPU and streams the register file and a data-memory window.
module sim_run_monitor #(
  parameter int unsigned CYCLE_LIMIT = 145,
  parameter logic [31:0] END_PC      = 32'h0000_3048,
  parameter int unsigned REG_NUM     = 32,
  parameter int unsigned MEM_BASE    = 20,
  parameter int unsigned MEM_WORDS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  output logic        cpu_hold,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [7:0]  mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic [7:0]  dump_idx,
  output logic        dump_is_mem,
  output logic        done,
  output logic [1:0]  cause,
  output logic [31:0] cycles,
  output logic [31:0] retired
);

  localparam int unsigned CW = 9;

  typedef enum logic [1:0] {RUN, DUMP_REG, DUMP_MEM, DONE} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  reg_cnt, mem_cnt;
  logic           halt, tmo, load;

  // Next-state logic; load means the output word slot is free or being taken this cycle.
  always_comb begin
    state_next = state;
    halt       = (state == RUN) && wb_valid && (wb_pc == END_PC);
    tmo        = (state == RUN) && (cycles == 32'(CYCLE_LIMIT - 1));
    load       = !dump_valid || dump_ready;
    case (state)
      RUN:      if (halt || tmo) state_next = DUMP_REG;
      DUMP_REG: if (load && (reg_cnt == CW'(REG_NUM - 1))) state_next = DUMP_MEM;
      DUMP_MEM: if (load && (mem_cnt == CW'(MEM_WORDS))) state_next = DONE;
      DONE:     state_next = DONE;
      default:  state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      cpu_hold    <= 1'b0;
      rf_raddr    <= '0;
      mem_raddr   <= '0;
      dump_valid  <= 1'b0;
      dump_data   <= '0;
      dump_idx    <= '0;
      dump_is_mem <= 1'b0;
      done        <= 1'b0;
      cause       <= 2'b00;
      cycles      <= '0;
      retired     <= '0;
      reg_cnt     <= '0;
      mem_cnt     <= '0;
    end else begin
      state <= state_next;
      case (state)
        RUN: begin
          cycles <= cycles + 32'd1;
          if (wb_valid) retired <= retired + 32'd1;
          if (halt || tmo) begin
            cpu_hold  <= 1'b1;
            cause     <= halt ? 2'b01 : 2'b10;
            rf_raddr  <= '0;
            mem_raddr <= 8'(MEM_BASE);
            reg_cnt   <= '0;
            mem_cnt   <= '0;
          end
        end
        // Register words: data for rf_raddr was addressed on the previous edge.
        DUMP_REG: begin
          if (load) begin
            dump_valid  <= 1'b1;
            dump_is_mem <= 1'b0;
            dump_idx    <= 8'(reg_cnt);
            dump_data   <= (reg_cnt == '0) ? 32'd0 : rf_rdata;
            rf_raddr    <= 5'(reg_cnt + CW'(1));
            reg_cnt     <= reg_cnt + CW'(1);
          end
        end
        // mem_raddr was preloaded at run end, so no gap after the last register word.
        DUMP_MEM: begin
          if (load) begin
            if (mem_cnt == CW'(MEM_WORDS)) begin
              dump_valid <= 1'b0;
              done       <= 1'b1;
            end else begin
              dump_valid  <= 1'b1;
              dump_is_mem <= 1'b1;
              dump_idx    <= mem_raddr;
              dump_data   <= mem_rdata;
              mem_raddr   <= mem_raddr + 8'd1;
              mem_cnt     <= mem_cnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_run_monitor.sv
// Bench for sim_run_monitor: scenario table with random retirement/backpressure
// checked against a queue-based model of the expected run result and dump stream.
module tb_sim_run_monitor;

  localparam int unsigned CYCLE_LIMIT = 145;
  localparam logic [31:0] END_PC      = 32'h0000_3048;
  localparam int unsigned REG_NUM     = 32;
  localparam int unsigned MEM_BASE    = 20;
  localparam int unsigned MEM_WORDS   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = '0;
  logic        cpu_hold;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [7:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [31:0] dump_data;
  logic [7:0]  dump_idx;
  logic        dump_is_mem;
  logic        done;
  logic [1:0]  cause;
  logic [31:0] cycles;
  logic [31:0] retired;

  logic [31:0] rf  [32];
  logic [31:0] mem [256];

  assign rf_rdata  = rf[rf_raddr];
  assign mem_rdata = mem[mem_raddr];

  always #5 clk = ~clk;

  sim_run_monitor #(
    .CYCLE_LIMIT(CYCLE_LIMIT), .END_PC(END_PC), .REG_NUM(REG_NUM),
    .MEM_BASE(MEM_BASE), .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .cpu_hold(cpu_hold), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_idx(dump_idx),
    .dump_is_mem(dump_is_mem), .done(done), .cause(cause),
    .cycles(cycles), .retired(retired)
  );

  typedef struct {
    int          halt_at;    // RUN edge carrying END_PC, 0 = never
    int          ready_pct;
    int          rst_word;   // words accepted before reset, -1 = none
    int          stall_word; // word before which ready drops 3 cycles, -1 = none
    logic [1:0]  exp_cause;
    logic [31:0] exp_cycles;
  } scen_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " flags"}, 64'({cpu_hold, dump_valid, done, cause, dump_is_mem}), 64'd0);
    chk({tag, " counters"}, {cycles, retired}, 64'd0);
    chk({tag, " addrs"}, 64'({rf_raddr, mem_raddr}), 64'd0);
    chk({tag, " dump"}, 64'({dump_data, dump_idx}), 64'd0);
  endtask

  task automatic run_scenario(input scen_t s, input bit fixed_vals);
    logic [40:0] exp_q[$];
    logic [40:0] w, prev_w;
    int final_edge, exp_ret, popped, budget, bubbles, stall_left;
    bit seen_valid, prev_stall, stalled;

    rst = 1'b1; wb_valid = 1'b0; dump_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    foreach (rf[i])  rf[i]  = $urandom;
    foreach (mem[i]) mem[i] = $urandom;
    if (fixed_vals) begin rf[1] = 32'h11; mem[MEM_BASE] = 32'h5; end

    // Expected dump stream: r0 forced to zero, then registers, then the memory window.
    exp_q = {};
    for (int i = 0; i < int'(REG_NUM); i++)
      exp_q.push_back({1'b0, 8'(i), (i == 0) ? 32'd0 : rf[i]});
    for (int i = 0; i < int'(MEM_WORDS); i++)
      exp_q.push_back({1'b1, 8'((MEM_BASE + i) % 256), mem[(MEM_BASE + i) % 256]});

    final_edge = (s.halt_at >= 1 && s.halt_at <= int'(CYCLE_LIMIT)) ? s.halt_at : int'(CYCLE_LIMIT);
    exp_ret = 0;
    rst = 1'b0;
    for (int e = 1; e <= final_edge; e++) begin
      chk("cycles running", 64'(cycles), 64'(e - 1));
      if (e == s.halt_at) begin
        wb_valid = 1'b1; wb_pc = END_PC;
      end else begin
        wb_valid = 1'($urandom_range(1));
        wb_pc = $urandom;
        if (wb_pc == END_PC) wb_pc = END_PC + 32'd4;
      end
      if (wb_valid) exp_ret++;
      if (e == final_edge) chk("hold before end", 64'({cpu_hold, cause}), 64'd0);
      @(posedge clk); @(negedge clk);
    end
    wb_valid = 1'b1; wb_pc = END_PC;
    chk("cause", 64'(cause), 64'(s.exp_cause));
    chk("cycles at end", 64'(cycles), 64'(s.exp_cycles));
    chk("retired at end", 64'(retired), 64'(exp_ret));
    chk("cpu_hold after end", 64'({cpu_hold, done}), 64'b10);

    popped = 0; budget = 0; bubbles = 0; stall_left = 0;
    seen_valid = 0; prev_stall = 0; stalled = 0; prev_w = '0;
    while (!done && budget < 3000) begin
      wb_valid = 1'($urandom_range(1));
      if (s.rst_word >= 0 && popped == s.rst_word) begin
        rst = 1'b1;
        #1;
        chk_zero("mid-dump reset");
        return;
      end
      w = {dump_is_mem, dump_idx, dump_data};
      if (prev_stall) chk("stable under backpressure", 64'(w), 64'(prev_w));
      if (!stalled && s.stall_word == popped && dump_valid) begin
        stall_left = 3; stalled = 1;
      end
      if (stall_left > 0) begin
        dump_ready = 1'b0; stall_left--;
      end else begin
        dump_ready = ($urandom_range(99) < s.ready_pct);
      end
      if (dump_valid) seen_valid = 1;
      else if (seen_valid) bubbles++;
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) chk("extra dump word", 64'(w), 64'h1_0000_0000_00);
        else chk("dump word", 64'(w), 64'(exp_q.pop_front()));
        popped++;
      end
      prev_stall = dump_valid && !dump_ready;
      prev_w = w;
      @(posedge clk); @(negedge clk);
      budget++;
    end
    chk("dump finished in budget", 64'(done), 64'd1);
    chk("dump word count", 64'(popped), 64'(REG_NUM + MEM_WORDS));
    chk("valid low when done", 64'(dump_valid), 64'd0);
    if (s.ready_pct == 100 && s.stall_word < 0) chk("no bubbles", 64'(bubbles), 64'd0);
    repeat (3) begin
      wb_valid = 1'b1; wb_pc = END_PC; dump_ready = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    chk("frozen counters", {cycles, retired}, {s.exp_cycles, 32'(exp_ret)});
    chk("final status", 64'({cpu_hold, done, dump_valid, cause}), 64'({3'b110, s.exp_cause}));
  endtask

  scen_t tbl[7];

  initial begin
    tbl[0] = '{halt_at: 60,  ready_pct: 100, rst_word: -1, stall_word: -1, exp_cause: 2'b01, exp_cycles: 32'd60};
    tbl[1] = '{halt_at: 0,   ready_pct: 100, rst_word: -1, stall_word: -1, exp_cause: 2'b10, exp_cycles: 32'd145};
    tbl[2] = '{halt_at: 0,   ready_pct: 100, rst_word: -1, stall_word: 7,  exp_cause: 2'b10, exp_cycles: 32'd145};
    tbl[3] = '{halt_at: 145, ready_pct: 60,  rst_word: -1, stall_word: -1, exp_cause: 2'b01, exp_cycles: 32'd145};
    tbl[4] = '{halt_at: 40,  ready_pct: 70,  rst_word: 10, stall_word: -1, exp_cause: 2'b01, exp_cycles: 32'd40};
    tbl[5] = '{halt_at: 25,  ready_pct: 50,  rst_word: -1, stall_word: 33, exp_cause: 2'b01, exp_cycles: 32'd25};
    tbl[6] = '{halt_at: 1,   ready_pct: 100, rst_word: -1, stall_word: -1, exp_cause: 2'b01, exp_cycles: 32'd1};

    for (int i = 0; i < 7; i++) run_scenario(tbl[i], i < 2);

    // Reset pulse in the middle of RUN restarts counting from zero.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    wb_valid = 1'b1; wb_pc = 32'h100;
    repeat (5) @(negedge clk);
    rst = 1'b1; #1;
    chk_zero("reset during run");
    @(negedge clk); rst = 1'b0; wb_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("restart count", {cycles, retired}, {32'd3, 32'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
